// File: rtl/goruntu_pkg.sv
// ---------------------------------------------------------------------------
// goruntu_pkg
//   Shared constants and types for the frame-streaming controller that sits
//   between RAM1 (source pixels), the image-processing core and RAM2
//   (results).
//   PIKSEL_SAYISI : pixels per frame (320x240)
//   ADR_W         : RAM address width, 2**ADR_W >= PIKSEL_SAYISI
//   VERI_W        : pixel width
//   gonder_durum_e: send-side FSM state encoding
// ---------------------------------------------------------------------------
package goruntu_pkg;

    localparam int PIKSEL_SAYISI = 76800;
    localparam int ADR_W         = 17;
    localparam int VERI_W        = 8;

    typedef enum logic [2:0] {
        BOSTA     = 3'd0,
        OKU       = 3'd1,
        BEKLE     = 3'd2,
        GONDER    = 3'd3,
        SON_BEKLE = 3'd4,
        BITTI     = 3'd5
    } gonder_durum_e;

endpackage

// File: rtl/goruntu_akis_denetleyici_piksel_yazici.sv
// ---------------------------------------------------------------------------
// piksel_yazici
//   RAM2 write path. Every valid core result is written, in arrival order,
//   to the next RAM2 address while the frame has room. A result arriving
//   once the frame is full is dropped and flagged through the sticky
//   fazla_o bit. The core has no backpressure, so a result is either taken
//   in the cycle it is presented or lost.
//
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   temizle_i       : accepted frame start; clears counter and fazla_o
//   etkin_i         : frame in progress (results are only taken then)
//   gecerli_i       : core result valid
//   veri_i          : core result data
//   yazilan_o       : number of results written this frame
//   fazla_o         : sticky, result seen after frame was full
//   ram2_*_o        : registered RAM2 write port
// ---------------------------------------------------------------------------
module piksel_yazici #(
    parameter int PIKSEL_SAYISI = goruntu_pkg::PIKSEL_SAYISI,
    parameter int ADR_W         = goruntu_pkg::ADR_W,
    parameter int VERI_W        = goruntu_pkg::VERI_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              temizle_i,
    input  logic              etkin_i,
    input  logic              gecerli_i,
    input  logic [VERI_W-1:0] veri_i,
    output logic [ADR_W:0]    yazilan_o,
    output logic              fazla_o,
    output logic              ram2_en_o,
    output logic              ram2_we_o,
    output logic [ADR_W-1:0]  ram2_addr_o,
    output logic [VERI_W-1:0] ram2_veri_o
);
    import goruntu_pkg::*;

    localparam logic [ADR_W:0] TAM = (ADR_W+1)'(PIKSEL_SAYISI);
    localparam logic [ADR_W:0] BIR = (ADR_W+1)'(1);

    logic [ADR_W:0]    yazilan_q,   yazilan_d;
    logic              fazla_q,     fazla_d;
    logic              ram2_en_q,   ram2_en_d;
    logic              ram2_we_q,   ram2_we_d;
    logic [ADR_W-1:0]  ram2_addr_q, ram2_addr_d;
    logic [VERI_W-1:0] ram2_veri_q, ram2_veri_d;
    logic              yer_var;

    always_comb begin
        yazilan_d   = yazilan_q;
        fazla_d     = fazla_q;
        ram2_en_d   = 1'b0;
        ram2_we_d   = 1'b0;
        ram2_addr_d = ram2_addr_q;
        ram2_veri_d = ram2_veri_q;
        yer_var     = (yazilan_q < TAM);

        if (temizle_i) begin
            yazilan_d = '0;
            fazla_d   = 1'b0;
        end else if (etkin_i && gecerli_i) begin
            if (yer_var) begin
                ram2_en_d   = 1'b1;
                ram2_we_d   = 1'b1;
                ram2_addr_d = yazilan_q[ADR_W-1:0];
                ram2_veri_d = veri_i;
                yazilan_d   = yazilan_q + BIR;
            end else begin
                // frame already full: drop the result, remember it
                fazla_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            yazilan_q   <= '0;
            fazla_q     <= 1'b0;
            ram2_en_q   <= 1'b0;
            ram2_we_q   <= 1'b0;
            ram2_addr_q <= '0;
            ram2_veri_q <= '0;
        end else begin
            yazilan_q   <= yazilan_d;
            fazla_q     <= fazla_d;
            ram2_en_q   <= ram2_en_d;
            ram2_we_q   <= ram2_we_d;
            ram2_addr_q <= ram2_addr_d;
            ram2_veri_q <= ram2_veri_d;
        end
    end

    assign yazilan_o   = yazilan_q;
    assign fazla_o     = fazla_q;
    assign ram2_en_o   = ram2_en_q;
    assign ram2_we_o   = ram2_we_q;
    assign ram2_addr_o = ram2_addr_q;
    assign ram2_veri_o = ram2_veri_q;

endmodule

// File: rtl/goruntu_akis_denetleyici.sv
// ---------------------------------------------------------------------------
// goruntu_akis_denetleyici
//   Streams one frame: reads pixels from RAM1, hands them to the processing
//   core over valid/ready, and lets piksel_yazici store the core results in
//   RAM2. Reports busy, done, missing-result and overflow status.
//
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   baslat_i              : start pulse, honoured in BOSTA and BITTI only
//   mesgul_o              : frame in progress
//   son_o                 : frame complete (level until next start)
//   eksik_o               : core finished with results missing (sticky)
//   fazla_o               : result arrived after frame full (sticky)
//   ram1_en_o/addr_o      : RAM1 read port, data on ram1_veri_i one cycle later
//   islem_en_o            : core enable
//   islem_veri_o/gecerli_o: pixel to core, islem_hazir_i accepts it
//   islem_veri_i/gecerli_i: core result (no backpressure)
//   islem_bitti_i         : core reports frame finished
//   ram2_*_o              : RAM2 write port
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   BOSTA     | idle after reset, waiting for start
//   OKU       | RAM1 read issued for pixel okunan
//   BEKLE     | RAM1 latency cycle, data captured on exit
//   GONDER    | pixel offered to core until accepted
//   SON_BEKLE | all pixels sent, waiting for all results or core finish
//   BITTI     | frame done, status held, waiting for next start
// ---------------------------------------------------------------------------
module goruntu_akis_denetleyici #(
    parameter int PIKSEL_SAYISI = goruntu_pkg::PIKSEL_SAYISI,
    parameter int ADR_W         = goruntu_pkg::ADR_W,
    parameter int VERI_W        = goruntu_pkg::VERI_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              baslat_i,
    output logic              mesgul_o,
    output logic              son_o,
    output logic              eksik_o,
    output logic              fazla_o,
    output logic              ram1_en_o,
    output logic [ADR_W-1:0]  ram1_addr_o,
    input  logic [VERI_W-1:0] ram1_veri_i,
    output logic              islem_en_o,
    output logic [VERI_W-1:0] islem_veri_o,
    output logic              islem_gecerli_o,
    input  logic              islem_hazir_i,
    input  logic [VERI_W-1:0] islem_veri_i,
    input  logic              islem_gecerli_i,
    input  logic              islem_bitti_i,
    output logic              ram2_en_o,
    output logic              ram2_we_o,
    output logic [ADR_W-1:0]  ram2_addr_o,
    output logic [VERI_W-1:0] ram2_veri_o
);
    import goruntu_pkg::*;

    localparam logic [ADR_W:0] TAM     = (ADR_W+1)'(PIKSEL_SAYISI);
    localparam logic [ADR_W:0] SON_IDX = (ADR_W+1)'(PIKSEL_SAYISI - 1);
    localparam logic [ADR_W:0] BIR     = (ADR_W+1)'(1);

    gonder_durum_e     durum_q,      durum_d;
    logic [ADR_W:0]    okunan_q,     okunan_d;
    logic [ADR_W:0]    gonderilen_q, gonderilen_d;
    logic              mesgul_q,     mesgul_d;
    logic              son_q,        son_d;
    logic              eksik_q,      eksik_d;
    logic              ram1_en_q,    ram1_en_d;
    logic [ADR_W-1:0]  ram1_addr_q,  ram1_addr_d;
    logic              islem_en_q,   islem_en_d;
    logic [VERI_W-1:0] islem_veri_q, islem_veri_d;
    logic              gecerli_q,    gecerli_d;

    logic              basla;
    logic [ADR_W:0]    yazilan;

    assign basla = baslat_i && ((durum_q == BOSTA) || (durum_q == BITTI));

    piksel_yazici #(
        .PIKSEL_SAYISI (PIKSEL_SAYISI),
        .ADR_W         (ADR_W),
        .VERI_W        (VERI_W)
    ) u_piksel_yazici (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .temizle_i   (basla),
        .etkin_i     (mesgul_q),
        .gecerli_i   (islem_gecerli_i),
        .veri_i      (islem_veri_i),
        .yazilan_o   (yazilan),
        .fazla_o     (fazla_o),
        .ram2_en_o   (ram2_en_o),
        .ram2_we_o   (ram2_we_o),
        .ram2_addr_o (ram2_addr_o),
        .ram2_veri_o (ram2_veri_o)
    );

    always_comb begin
        durum_d      = durum_q;
        okunan_d     = okunan_q;
        gonderilen_d = gonderilen_q;
        mesgul_d     = mesgul_q;
        son_d        = son_q;
        eksik_d      = eksik_q;
        ram1_en_d    = ram1_en_q;
        ram1_addr_d  = ram1_addr_q;
        islem_en_d   = islem_en_q;
        islem_veri_d = islem_veri_q;
        gecerli_d    = gecerli_q;

        case (durum_q)
            BOSTA, BITTI: begin
                if (baslat_i) begin
                    // first read goes out with the start, so address 0 is
                    // already on the RAM1 port in the first OKU cycle
                    durum_d      = OKU;
                    mesgul_d     = 1'b1;
                    islem_en_d   = 1'b1;
                    son_d        = 1'b0;
                    eksik_d      = 1'b0;
                    ram1_en_d    = 1'b1;
                    ram1_addr_d  = '0;
                    okunan_d     = BIR;
                    gonderilen_d = '0;
                end
            end
            OKU: begin
                durum_d   = BEKLE;
                ram1_en_d = 1'b0;
            end
            BEKLE: begin
                durum_d      = GONDER;
                islem_veri_d = ram1_veri_i;
                gecerli_d    = 1'b1;
            end
            GONDER: begin
                if (islem_hazir_i) begin
                    gecerli_d    = 1'b0;
                    gonderilen_d = gonderilen_q + BIR;
                    // okunan guard keeps reads inside the frame even if the
                    // two counters were ever to disagree
                    if ((gonderilen_q == SON_IDX) || (okunan_q >= TAM)) begin
                        durum_d = SON_BEKLE;
                    end else begin
                        durum_d     = OKU;
                        ram1_en_d   = 1'b1;
                        ram1_addr_d = okunan_q[ADR_W-1:0];
                        okunan_d    = okunan_q + BIR;
                    end
                end
            end
            SON_BEKLE: begin
                // a full frame takes priority over a simultaneous finish
                if (yazilan == TAM) begin
                    durum_d    = BITTI;
                    son_d      = 1'b1;
                    mesgul_d   = 1'b0;
                    islem_en_d = 1'b0;
                end else if (islem_bitti_i) begin
                    durum_d    = BITTI;
                    son_d      = 1'b1;
                    eksik_d    = 1'b1;
                    mesgul_d   = 1'b0;
                    islem_en_d = 1'b0;
                end
            end
            default: begin
                durum_d    = BOSTA;
                mesgul_d   = 1'b0;
                islem_en_d = 1'b0;
                ram1_en_d  = 1'b0;
                gecerli_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q      <= BOSTA;
            okunan_q     <= '0;
            gonderilen_q <= '0;
            mesgul_q     <= 1'b0;
            son_q        <= 1'b0;
            eksik_q      <= 1'b0;
            ram1_en_q    <= 1'b0;
            ram1_addr_q  <= '0;
            islem_en_q   <= 1'b0;
            islem_veri_q <= '0;
            gecerli_q    <= 1'b0;
        end else begin
            durum_q      <= durum_d;
            okunan_q     <= okunan_d;
            gonderilen_q <= gonderilen_d;
            mesgul_q     <= mesgul_d;
            son_q        <= son_d;
            eksik_q      <= eksik_d;
            ram1_en_q    <= ram1_en_d;
            ram1_addr_q  <= ram1_addr_d;
            islem_en_q   <= islem_en_d;
            islem_veri_q <= islem_veri_d;
            gecerli_q    <= gecerli_d;
        end
    end

    assign mesgul_o        = mesgul_q;
    assign son_o           = son_q;
    assign eksik_o         = eksik_q;
    assign ram1_en_o       = ram1_en_q;
    assign ram1_addr_o     = ram1_addr_q;
    assign islem_en_o      = islem_en_q;
    assign islem_veri_o    = islem_veri_q;
    assign islem_gecerli_o = gecerli_q;

endmodule

// File: tb/tb_goruntu_akis_denetleyici.sv
module tb_goruntu_akis_denetleyici;

    localparam int N  = 16;
    localparam int AW = goruntu_pkg::ADR_W;
    localparam int VW = goruntu_pkg::VERI_W;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          baslat_i;
    logic          mesgul_o, son_o, eksik_o, fazla_o;
    logic          ram1_en_o;
    logic [AW-1:0] ram1_addr_o;
    logic [VW-1:0] ram1_veri_i;
    logic          islem_en_o;
    logic [VW-1:0] islem_veri_o;
    logic          islem_gecerli_o;
    logic          islem_hazir_i;
    logic [VW-1:0] islem_veri_i;
    logic          islem_gecerli_i;
    logic          islem_bitti_i;
    logic          ram2_en_o, ram2_we_o;
    logic [AW-1:0] ram2_addr_o;
    logic [VW-1:0] ram2_veri_o;

    goruntu_akis_denetleyici #(
        .PIKSEL_SAYISI (N),
        .ADR_W         (AW),
        .VERI_W        (VW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .baslat_i        (baslat_i),
        .mesgul_o        (mesgul_o),
        .son_o           (son_o),
        .eksik_o         (eksik_o),
        .fazla_o         (fazla_o),
        .ram1_en_o       (ram1_en_o),
        .ram1_addr_o     (ram1_addr_o),
        .ram1_veri_i     (ram1_veri_i),
        .islem_en_o      (islem_en_o),
        .islem_veri_o    (islem_veri_o),
        .islem_gecerli_o (islem_gecerli_o),
        .islem_hazir_i   (islem_hazir_i),
        .islem_veri_i    (islem_veri_i),
        .islem_gecerli_i (islem_gecerli_i),
        .islem_bitti_i   (islem_bitti_i),
        .ram2_en_o       (ram2_en_o),
        .ram2_we_o       (ram2_we_o),
        .ram2_addr_o     (ram2_addr_o),
        .ram2_veri_o     (ram2_veri_o)
    );

    always #5 clk_i = ~clk_i;

    int dogrulama_sayisi = 0;
    int hata_sayisi      = 0;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        dogrulama_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: gozlenen=%0h beklenen=%0h", etiket, gozlenen, beklenen);
        end
    endtask

    // RAM1: synchronous read, RAM1[i] = i + 8'h10
    logic [VW-1:0] ram1 [0:N-1];
    initial for (int i = 0; i < N; i++) ram1[i] = 8'h10 + 8'(i);

    always @(posedge clk_i)
        if (ram1_en_o)
            ram1_veri_i <= (ram1_addr_o < N) ? ram1[ram1_addr_o[3:0]] : 8'hEE;

    // RAM2 model and per-frame counters
    logic [VW-1:0] ram2 [0:N-1];
    int  yazma_sayisi   = 0;
    int  aktarim_sayisi = 0;
    int  uretilen       = 0;
    logic yeni_kare;
    assign yeni_kare = baslat_i && !mesgul_o;

    always @(posedge clk_i) begin
        if (yeni_kare) begin
            for (int i = 0; i < N; i++) ram2[i] <= 8'h00;
            yazma_sayisi <= 0;
        end else if (ram2_en_o && ram2_we_o) begin
            if (ram2_addr_o < N) ram2[ram2_addr_o[3:0]] <= ram2_veri_o;
            yazma_sayisi <= yazma_sayisi + 1;
        end
    end

    // core model: result = ~pixel, two cycles after the transfer
    logic          v1 = 1'b0, v2 = 1'b0, ekstra_v = 1'b0;
    logic [VW-1:0] d1, d2;
    bit            dusur_modu = 1'b0;
    bit            fazla_modu = 1'b0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            ekstra_v <= 1'b0;
        end else begin
            v1       <= islem_gecerli_o && islem_hazir_i;
            d1       <= ~islem_veri_o;
            v2       <= v1;
            d2       <= d1;
            ekstra_v <= fazla_modu && v2 && (uretilen == N - 1);
        end
    end

    always @(posedge clk_i) begin
        if (yeni_kare) begin
            aktarim_sayisi <= 0;
            uretilen       <= 0;
        end else begin
            if (islem_gecerli_o && islem_hazir_i) aktarim_sayisi <= aktarim_sayisi + 1;
            if (v2) uretilen <= uretilen + 1;
        end
    end

    assign islem_gecerli_i = (v2 && !(dusur_modu && uretilen == 9)) || ekstra_v;
    assign islem_veri_i    = ekstra_v ? 8'h5A : d2;

    task automatic baslat();
        @(negedge clk_i);
        baslat_i = 1'b1;
        @(negedge clk_i);
        baslat_i = 1'b0;
    endtask

    task automatic son_bekle(input string etiket);
        int n;
        n = 0;
        while (!son_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        kontrol({etiket, "_zaman"}, 32'(son_o), 32'd1);
    endtask

    task automatic piksel_bekle(input logic [VW-1:0] deger, input string etiket);
        int n;
        n = 0;
        while (!(islem_gecerli_o && islem_veri_o == deger) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        kontrol({etiket, "_bul"}, 32'(islem_gecerli_o && islem_veri_o == deger), 32'd1);
    endtask

    task automatic sifir_kontrol(input string etiket);
        kontrol({etiket, "_bayrak"},
                {23'd0, mesgul_o, son_o, eksik_o, fazla_o, ram1_en_o, islem_en_o,
                 islem_gecerli_o, ram2_en_o, ram2_we_o}, 32'd0);
        kontrol({etiket, "_adr1"}, 32'(ram1_addr_o), 32'd0);
        kontrol({etiket, "_adr2"}, 32'(ram2_addr_o), 32'd0);
        kontrol({etiket, "_veri"}, {16'd0, islem_veri_o, ram2_veri_o}, 32'd0);
    endtask

    task automatic kare_kontrol(input string etiket, input logic bek_eksik,
                                input logic bek_fazla, input int bek_yazma,
                                input int atlanan);
        int            kaynak;
        logic [VW-1:0] bek;
        kontrol({etiket, "_son"},    32'(son_o),     32'd1);
        kontrol({etiket, "_mesgul"}, 32'(mesgul_o),  32'd0);
        kontrol({etiket, "_en"},     32'(islem_en_o), 32'd0);
        kontrol({etiket, "_eksik"},  32'(eksik_o),   32'(bek_eksik));
        kontrol({etiket, "_fazla"},  32'(fazla_o),   32'(bek_fazla));
        kontrol({etiket, "_aktarim"}, aktarim_sayisi, N);
        kontrol({etiket, "_yazma"},   yazma_sayisi,   bek_yazma);
        for (int i = 0; i < N; i++) begin
            kaynak = (atlanan >= 0 && i >= atlanan) ? i + 1 : i;
            bek    = (kaynak < N) ? ~(8'(kaynak) + 8'h10) : 8'h00;
            kontrol($sformatf("%s_ram2_%0d", etiket, i), 32'(ram2[i]), 32'(bek));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i         = 1'b1;
        baslat_i      = 1'b0;
        islem_hazir_i = 1'b1;
        islem_bitti_i = 1'b0;
        repeat (3) @(negedge clk_i);
        sifir_kontrol("reset");
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // frame 1: always ready; stray start and early finish are ignored
        baslat();
        kontrol("k1_basla", {30'd0, mesgul_o, islem_en_o}, 32'd3);
        repeat (6) @(negedge clk_i);
        baslat_i      = 1'b1;
        islem_bitti_i = 1'b1;
        @(negedge clk_i);
        baslat_i      = 1'b0;
        islem_bitti_i = 1'b0;
        son_bekle("k1");
        kare_kontrol("k1", 1'b0, 1'b0, N, -1);

        // frame 2 from BITTI: core stalls 5 cycles on pixel 7
        baslat();
        kontrol("k2_basla", {30'd0, son_o, mesgul_o}, 32'd1);
        piksel_bekle(8'h17, "k2_p7");
        islem_hazir_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            kontrol($sformatf("k2_tut_%0d", i), {23'd0, islem_gecerli_o, islem_veri_o},
                    {23'd0, 1'b1, 8'h17});
        end
        islem_hazir_i = 1'b1;
        son_bekle("k2");
        kare_kontrol("k2", 1'b0, 1'b0, N, -1);

        // frame 3: result 9 lost, core then reports finished
        dusur_modu = 1'b1;
        baslat();
        begin
            int n;
            n = 0;
            while (aktarim_sayisi < N && n < 400) begin
                @(negedge clk_i);
                n++;
            end
        end
        kontrol("k3_aktarim", aktarim_sayisi, N);
        repeat (8) @(negedge clk_i);
        kontrol("k3_bekliyor", {30'd0, son_o, mesgul_o}, 32'd1);
        islem_bitti_i = 1'b1;
        @(negedge clk_i);
        islem_bitti_i = 1'b0;
        son_bekle("k3");
        kare_kontrol("k3", 1'b1, 1'b0, N - 1, 9);
        dusur_modu = 1'b0;

        // frame 4: core emits a 17th result
        fazla_modu = 1'b1;
        baslat();
        kontrol("k4_eksik_temiz", 32'(eksik_o), 32'd0);
        son_bekle("k4");
        kare_kontrol("k4", 1'b0, 1'b1, N, -1);
        fazla_modu = 1'b0;

        // frame 5: reset in the middle, then a clean frame
        baslat();
        kontrol("k5_fazla_temiz", 32'(fazla_o), 32'd0);
        piksel_bekle(8'h15, "k5_p5");
        rst_i = 1'b1;
        #1;
        sifir_kontrol("k5_rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        kontrol("k5_bosta", {30'd0, mesgul_o, islem_en_o}, 32'd0);
        baslat();
        son_bekle("k6");
        kare_kontrol("k6", 1'b0, 1'b0, N, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 dogrulama_sayisi, hata_sayisi);
        $finish;
    end

endmodule
